// File: rtl/wb_resp_pkg.sv
// Shared types and constants for the Wishbone DDR3 stand-in responder.
// State encoding, LFSR seed/taps and the latency ceiling.
package wb_resp_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          LATENCY_MAX = 16;

endpackage

// File: rtl/wb_ddr3_responder_if.sv
// Pipelined Wishbone bus between a master and the DDR3 responder.
// master drives the request side, slave drives stall/ack/data/aux.
interface wb_ddr3_responder_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 128,
    parameter int AUX_WIDTH = 4
);
    logic                   i_wb_cyc;
    logic                   i_wb_stb;
    logic                   i_wb_we;
    logic [ADDR_BITS-1:0]   i_wb_addr;
    logic [DATA_BITS-1:0]   i_wb_data;
    logic [DATA_BITS/8-1:0] i_wb_sel;
    logic [AUX_WIDTH-1:0]   i_aux;
    logic                   o_wb_stall;
    logic                   o_wb_ack;
    logic [DATA_BITS-1:0]   o_wb_data;
    logic [AUX_WIDTH-1:0]   o_aux;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we,
        output i_wb_addr, i_wb_data, i_wb_sel, i_aux,
        input  o_wb_stall, o_wb_ack, o_wb_data, o_aux
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we,
        input  i_wb_addr, i_wb_data, i_wb_sel, i_aux,
        output o_wb_stall, o_wb_ack, o_wb_data, o_aux
    );
endinterface

// File: rtl/wb_resp_lfsr.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random stalls.
// Holds its value while i_en is low; restarts from the seed on reset.
module wb_resp_lfsr
    import wb_resp_pkg::*;
(
    input  logic        i_controller_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_q
);
    logic fb;

    assign fb = ^(o_q & LFSR_TAPS);

    // shift in the tap parity when enabled
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= LFSR_SEED;
        end else if (i_en) begin
            o_q <= {o_q[14:0], fb};
        end
    end
endmodule

// File: rtl/wb_ddr3_responder.sv
// RAM-backed pipelined Wishbone slave standing in for the DDR3 controller.
// Define WB_RESP_STALL_INJECT_EN to add LFSR-driven random stalls.
module wb_ddr3_responder
    import wb_resp_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 128,
    parameter int AUX_WIDTH     = 4,
    parameter int LATENCY       = 4,
    parameter int OPT_BUS_ABORT = 1,
    parameter int INIT_CLEAR    = 1
) (
    input  logic                i_controller_clk,
    input  logic                i_rst_n,
    wb_ddr3_responder_if.slave  bus,
    output logic                o_init_done
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int NB    = DATA_BITS / 8;

    state_t               state;
    state_t               state_nx;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] cnt_nx;
    logic                 clr_we;
    logic                 inject;
    logic                 stall;
    logic                 abort;
    logic                 accept;
    logic                 ack_live;

    logic                 vld  [LATENCY];
    logic                 wrq  [LATENCY];
    logic [AUX_WIDTH-1:0] auxq [LATENCY];

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_q;
    logic [DATA_BITS-1:0] data_last;

`ifdef WB_RESP_STALL_INJECT_EN
    logic [15:0] lfsr_q;

    wb_resp_lfsr u_lfsr (
        .i_controller_clk (i_controller_clk),
        .i_rst_n          (i_rst_n),
        .i_en             (state == READY),
        .o_q              (lfsr_q)
    );

    assign inject = (lfsr_q[1:0] == 2'b00);
`else
    assign inject = 1'b0;
`endif

    assign stall  = (state != READY) | inject;
    assign abort  = (OPT_BUS_ABORT != 0) & ~bus.i_wb_cyc;
    assign accept = bus.i_wb_stb & ~stall
                  & (bus.i_wb_cyc | (OPT_BUS_ABORT == 0));

    // state and sweep counter registers
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // INIT sweeps one word per cycle, READY is terminal
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        unique case (state)
            INIT: begin
                if (INIT_CLEAR != 0) begin
                    clr_we = 1'b1;
                    cnt_nx = cnt + 1'b1;
                    if (cnt == {ADDR_BITS{1'b1}}) begin
                        state_nx = READY;
                    end
                end else begin
                    state_nx = READY;
                end
            end
            READY: begin
                state_nx = READY;
            end
        endcase
    end

    // block RAM: byte-masked write, read-first output register
    always_ff @(posedge i_controller_clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (accept && bus.i_wb_we) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.i_wb_sel[b]) begin
                    mem[bus.i_wb_addr][b*8 +: 8] <= bus.i_wb_data[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            rd_q <= mem[bus.i_wb_addr];
        end
    end

    // valid/kind/tag shift; an abort wipes every stage
    always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld[i]  <= 1'b0;
                wrq[i]  <= 1'b0;
                auxq[i] <= '0;
            end
        end else if (abort) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld[i] <= 1'b0;
            end
        end else begin
            vld[0]  <= accept;
            wrq[0]  <= bus.i_wb_we;
            auxq[0] <= bus.i_aux;
            for (int i = 1; i < LATENCY; i++) begin
                vld[i]  <= vld[i-1];
                wrq[i]  <= wrq[i-1];
                auxq[i] <= auxq[i-1];
            end
        end
    end

    // read data trails rd_q, which already holds stage 0
    if (LATENCY > 1) begin : g_dpipe
        logic [DATA_BITS-1:0] dq [LATENCY-1];

        // delay line for read data
        always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    dq[i] <= '0;
                end
            end else begin
                dq[0] <= rd_q;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    dq[i] <= dq[i-1];
                end
            end
        end

        assign data_last = dq[LATENCY-2];
    end else begin : g_dnone
        assign data_last = rd_q;
    end

    // bus-low cycle suppresses the ack being presented too
    assign ack_live      = vld[LATENCY-1] & ~abort;
    assign bus.o_wb_stall = stall;
    assign bus.o_wb_ack   = ack_live;
    assign bus.o_wb_data  = (ack_live & ~wrq[LATENCY-1]) ? data_last : '0;
    assign bus.o_aux      = ack_live ? auxq[LATENCY-1] : '0;
    assign o_init_done    = (state == READY);

endmodule

// File: tb/tb_wb_ddr3_responder.sv
// Bench for wb_ddr3_responder: two instances (bus abort on/off) fed
// the same directed stimulus, checked every cycle against a queue model.
module tb_wb_ddr3_responder;
    localparam int AB  = 8;
    localparam int DB  = 128;
    localparam int AW  = 4;
    localparam int LAT = 4;
    localparam int NW  = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic          cyc;
    logic          stb;
    logic          we;
    logic [7:0]    addr;
    logic [127:0]  wdata;
    logic [15:0]   sel;
    logic [3:0]    aux;
    logic          done0;
    logic          done1;

    wb_ddr3_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW)) b0 ();
    wb_ddr3_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW)) b1 ();

    assign b0.i_wb_cyc  = cyc;
    assign b0.i_wb_stb  = stb;
    assign b0.i_wb_we   = we;
    assign b0.i_wb_addr = addr;
    assign b0.i_wb_data = wdata;
    assign b0.i_wb_sel  = sel;
    assign b0.i_aux     = aux;
    assign b1.i_wb_cyc  = cyc;
    assign b1.i_wb_stb  = stb;
    assign b1.i_wb_we   = we;
    assign b1.i_wb_addr = addr;
    assign b1.i_wb_data = wdata;
    assign b1.i_wb_sel  = sel;
    assign b1.i_aux     = aux;

    wb_ddr3_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW),
        .LATENCY(LAT), .OPT_BUS_ABORT(1), .INIT_CLEAR(1)
    ) u0 (
        .i_controller_clk (clk),
        .i_rst_n          (rst_n),
        .bus              (b0),
        .o_init_done      (done0)
    );

    wb_ddr3_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .AUX_WIDTH(AW),
        .LATENCY(LAT), .OPT_BUS_ABORT(0), .INIT_CLEAR(1)
    ) u1 (
        .i_controller_clk (clk),
        .i_rst_n          (rst_n),
        .bus              (b1),
        .o_init_done      (done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int           d;
        int           due;
        logic [127:0] data;
        logic [3:0]   aux;
    } exp_t;

    typedef struct {
        int         m;
        logic [3:0] x;
    } log_t;

    exp_t         exp_q[$];
    log_t         ack_log[$];
    logic [127:0] mem_m [2][NW];
    int           me = 0;
    int           ack_cnt [2];

    initial begin
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
    end

    // model: ready after NW clocked edges, fixed-latency response queue
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            me = 0;
            exp_q.delete();
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < NW; a++)
                    mem_m[d][a] = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (stb && me >= NW && (cyc || d == 1)) begin
                    exp_t e;
                    e.d    = d;
                    e.due  = me + LAT;
                    e.data = we ? 128'h0 : mem_m[d][addr];
                    e.aux  = aux;
                    if (we)
                        for (int b = 0; b < 16; b++)
                            if (sel[b]) mem_m[d][addr][b*8 +: 8] = wdata[b*8 +: 8];
                    exp_q.push_back(e);
                end
            end
            me = me + 1;
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        logic         ak;
        logic         st;
        logic         dn;
        logic [127:0] dt;
        logic [3:0]   ax;
        int           idx;
        logic         eak;
        for (int d = 0; d < 2; d++) begin
            ak = (d == 0) ? b0.o_wb_ack   : b1.o_wb_ack;
            st = (d == 0) ? b0.o_wb_stall : b1.o_wb_stall;
            dt = (d == 0) ? b0.o_wb_data  : b1.o_wb_data;
            ax = (d == 0) ? b0.o_aux      : b1.o_aux;
            dn = (d == 0) ? done0         : done1;
            if (!rst_n) begin
                chk("rst_ack", {127'h0, ak}, 128'h0);
                chk("rst_stall", {127'h0, st}, 128'h1);
                chk("rst_done", {127'h0, dn}, 128'h0);
                chk("rst_data", dt, 128'h0);
                chk("rst_aux", {124'h0, ax}, 128'h0);
            end else begin
                if (d == 0 && !cyc)
                    for (int i = exp_q.size() - 1; i >= 0; i--)
                        if (exp_q[i].d == 0) exp_q.delete(i);
                chk("stall", {127'h0, st}, {127'h0, me < NW});
                chk("init_done", {127'h0, dn}, {127'h0, me >= NW});
                idx = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (idx < 0 && exp_q[i].d == d) idx = i;
                eak = (idx >= 0) && (exp_q[idx].due == me);
                chk("ack", {127'h0, ak}, {127'h0, eak});
                if (eak) begin
                    chk("ack_data", dt, exp_q[idx].data);
                    chk("ack_aux", {124'h0, ax}, {124'h0, exp_q[idx].aux});
                    exp_q.delete(idx);
                end else begin
                    chk("idle_data", dt, 128'h0);
                    chk("idle_aux", {124'h0, ax}, 128'h0);
                end
                if (ak) begin
                    ack_cnt[d]++;
                    if (d == 0) ack_log.push_back('{m: me, x: ax});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [7:0] a,
                        input logic [127:0] dat, input logic [15:0] s,
                        input logic [3:0] x);
        cyc = 1'b1; stb = 1'b1; we = w;
        addr = a; wdata = dat; sel = s; aux = x;
        tick();
        stb = 1'b0;
    endtask

    task automatic txn(input string nm, input logic w, input logic [7:0] a,
                       input logic [127:0] dat, input logic [15:0] s,
                       input logic [3:0] x, input logic [127:0] edat,
                       input logic [3:0] eaux);
        int n;
        send(w, a, dat, s, x);
        n = 1;
        while (!b0.o_wb_ack && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_lat"}, 128'(n), 128'(LAT));
        chk({nm, "_data"}, b0.o_wb_data, edat);
        chk({nm, "_aux"}, {124'h0, b0.o_aux}, {124'h0, eaux});
        tick();
    endtask

    task automatic wait_init(input string nm);
        int n;
        n = 0;
        while (!done0 && n < 1000) begin
            chk({nm, "_stall"}, {127'h0, b0.o_wb_stall}, 128'h1);
            tick();
            n++;
        end
        chk({nm, "_edges"}, 128'(n), 128'(NW));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int n0;
        int bme;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
        wdata = '0; sel = '0; aux = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("init");
        cyc = 1'b1;

        txn("rd5a", 1'b0, 8'h5A, 128'h0, 16'h0, 4'h2, 128'h0, 4'h2);
        txn("wr9e", 1'b1, 8'h9E, 128'h61, 16'hFFFF, 4'h1, 128'h0, 4'h1);
        txn("rd9e", 1'b0, 8'h9E, 128'h0, 16'h0, 4'h0, 128'h61, 4'h0);

        txn("wr3a", 1'b1, 8'h03, {128{1'b1}}, 16'hFFFF, 4'h3, 128'h0, 4'h3);
        txn("wr3b", 1'b1, 8'h03, 128'h0, 16'h0001, 4'h4, 128'h0, 4'h4);
        txn("wr3c", 1'b1, 8'h03, 128'h0, 16'h0000, 4'h5, 128'h0, 4'h5);
        txn("rd3", 1'b0, 8'h03, 128'h0, 16'h0, 4'h6,
            128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00, 4'h6);

        n0  = ack_log.size();
        bme = me;
        for (int i = 0; i < 8; i++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0;
            addr = 8'(i); aux = 4'(i);
            tick();
        end
        stb = 1'b0;
        repeat (8) tick();
        chk("burst_count", 128'(ack_log.size() - n0), 128'd8);
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < ack_log.size()) begin
                chk("burst_cycle", 128'(ack_log[n0+i].m), 128'(bme + LAT + i));
                chk("burst_aux", {124'h0, ack_log[n0+i].x}, 128'(i));
            end
        end

        c0 = ack_cnt[0];
        c1 = ack_cnt[1];
        for (int i = 0; i < 3; i++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0;
            addr = 8'(8'h10 + i); aux = 4'(8 + i);
            tick();
        end
        cyc = 1'b0; stb = 1'b0;
        tick();
        cyc = 1'b1;
        repeat (8) tick();
        chk("abort_acks_on", 128'(ack_cnt[0] - c0), 128'd0);
        chk("abort_acks_off", 128'(ack_cnt[1] - c1), 128'd3);

        c0 = ack_cnt[0];
        c1 = ack_cnt[1];
        cyc = 1'b0; stb = 1'b1; we = 1'b1; addr = 8'h40;
        wdata = 128'hABCD; sel = 16'hFFFF; aux = 4'h5;
        tick();
        stb = 1'b0; cyc = 1'b1;
        repeat (6) tick();
        chk("cyclow_stb_on", 128'(ack_cnt[0] - c0), 128'd0);
        chk("cyclow_stb_off", 128'(ack_cnt[1] - c1), 128'd1);
        txn("rd40", 1'b0, 8'h40, 128'h0, 16'h0, 4'h7, 128'h0, 4'h7);

        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 8'h41;
        wdata = 128'h1234; sel = 16'hFFFF; aux = 4'h6;
        tick();
        cyc = 1'b0; stb = 1'b0;
        tick();
        cyc = 1'b1;
        repeat (6) tick();
        txn("rd41", 1'b0, 8'h41, 128'h0, 16'h0, 4'h9, 128'h1234, 4'h9);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 8'h9E; aux = 4'hA;
        tick();
        addr = 8'h41; aux = 4'hB;
        tick();
        stb = 1'b0;
        tick();
        tick();
        chk("pre_rst_ack", {127'h0, b0.o_wb_ack}, 128'h1);
        c0 = ack_cnt[0];
        c1 = ack_cnt[1];
        rst_n = 1'b0;
        #1;
        chk("rst_now_ack0", {127'h0, b0.o_wb_ack}, 128'h0);
        chk("rst_now_ack1", {127'h0, b1.o_wb_ack}, 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("reinit");
        repeat (4) tick();
        chk("rst_no_acks0", 128'(ack_cnt[0] - c0), 128'd0);
        chk("rst_no_acks1", 128'(ack_cnt[1] - c1), 128'd0);
        txn("rd9e_clr", 1'b0, 8'h9E, 128'h0, 16'h0, 4'hC, 128'h0, 4'hC);
        txn("rd41_clr", 1'b0, 8'h41, 128'h0, 16'h0, 4'hD, 128'h0, 4'hD);

        repeat (4) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
